braille_hex_scroller: RTL and testbench
=======================================

// Module: braille_hex_scroller
// PURPOSE
//  Braille entry terminal for the DE-board. The user sets a 6-dot cell on SW[5:0]
//  and presses KEY[1] to commit it. The cell is decoded to a 7-segment glyph and
//  shifted into a NUM_DIGITS-wide scrolling text buffer driving the HEX displays.
//  It generalises the single-digit A-F decoder: full a-z, space, backspace,
//  debounced commit and N digits.
// PARAMETERS
//  NUM_DIGITS       4        number of HEX digits in the scroll buffer (1..8)
//  DEBOUNCE_CYCLES  500000   stable cycles required on KEY[1] (10 ms at 50 MHz)
// PORTS
//  CLOCK_50   in   1               sole clock, 50 MHz, rising edge
//  KEY[0]     in   1               reset, asynchronous, active-low
//  KEY[1]     in   1               commit button, active-low, asynchronous to clock
//  SW         in   6               braille cell: dot1=SW[0] dot4=SW[1] dot2=SW[2]
//                                  dot5=SW[3] dot3=SW[4] dot6=SW[5]
//  HEX_OUT    out  NUM_DIGITS*8    digit d occupies [d*8+7:d*8]
//                                  bit i = segment i (0=a..6=g), bit 7 = dp
//                                  active-low; digit 0 is rightmost (newest)
//  char_count out  4               committed characters held, saturates at NUM_DIGITS
//  commit     out  1               one-cycle pulse when a cell is committed
//  err        out  1               one-cycle pulse, coincident with commit, if the pattern is invalid
// BEHAVIOUR
//  - Reset (KEY[0]=0, async assert, sync release through 2-FF):
//    HEX_OUT all 1s (blank), char_count=0, commit=0, err=0, debouncer IDLE.
//  - Synchronisation: KEY[1] and SW each pass a 2-FF synchroniser before use.
//  - Debouncer FSM:
//    IDLE    -> ARMING  when synced KEY[1]=0; counter cleared.
//    ARMING  -> IDLE    if KEY[1] returns to 1 before DEBOUNCE_CYCLES.
//    ARMING  -> PRESSED when the counter reaches DEBOUNCE_CYCLES-1. On this
//               transition a one-cycle press strobe samples the synced SW.
//    PRESSED -> RELEASE when KEY[1]=1; counter cleared.
//    RELEASE -> IDLE    after DEBOUNCE_CYCLES stable high cycles.
//    RELEASE -> PRESSED if KEY[1]=0 again, with no new strobe.
//  - Exactly one strobe per physical press. Holding the key never repeats.
//  - Commit latency: strobe at cycle N; HEX_OUT, char_count, commit and err
//    update at edge N+1 (one registered decode stage).
//  - Decode of pattern P = SW (6 bits):
//    P=6'b000000 -> space: blank glyph 8'hFF shifts in.
//    P=6'b111111 -> backspace: buffer shifts toward digit 0 (digit d takes
//      digit d+1), the top digit becomes blank, char_count decrements.
//      Backspace with char_count=0 leaves everything unchanged; commit still pulses.
//    P in the 26-letter braille table -> its glyph shifts into digit 0.
//      The other digits move up by one; the top digit is discarded.
//    Any other P -> dash glyph 8'hBF shifts in, err=1.
//  - char_count: +1 on a shift-in (saturating at NUM_DIGITS), -1 on backspace
//    (floor 0). Space counts as a character.
//  - dp bit is always 1 (off). Digits never filled stay 8'hFF.
//  - SW changes between presses have no visible effect. HEX shows only committed cells.
//  - Reset during ARMING or PRESSED aborts the press. No commit occurs after release.
// STRUCTURE
//  - Package braille_pkg:
//    * seg_t (8-bit glyph type)
//    * constants GLYPH_BLANK=8'hFF, GLYPH_DASH=8'hBF, PAT_SPACE, PAT_BKSP
//    * function braille_to_glyph(P) -> {valid, seg_t}, covering a-z
//    * k, m, v, w, x use fixed approximations defined in the package
//  - Sub-module key_debouncer (synchroniser + FSM + counter, parameter
//    DEBOUNCE_CYCLES, output press_strobe). It is reused for other KEY inputs.
//  - Top level holds the decode register, shift buffer and count logic.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, NUM_DIGITS=4)
//  1 Reset, then press with SW=6'b000001 ('a')
//    -> HEX_OUT[7:0]=8'h88, others 8'hFF, char_count=1, commit pulses once, err=0.
//  2 Commit 'a', then SW=6'b000011 ('c')
//    -> digit0=8'hC6, digit1=8'h88, char_count=2.
//  3 Bounce KEY[1] low for 2 cycles, three times, then hold low for 10 cycles
//    -> exactly one commit pulse; holding 1000 more cycles adds none.
//  4 Commit 5 letters -> oldest letter lost, char_count=4.
//    Then 5 backspaces (6'b111111) -> all digits 8'hFF, char_count=0,
//    5th backspace changes nothing.
//  5 Press with SW=6'b101010 (not in table) -> digit0=8'hBF, err and commit pulse together.
//  6 Assert KEY[0] while in PRESSED with 3 chars held
//    -> outputs blank immediately (async); releasing KEY[1] afterwards gives no commit.

Source files
------------

// File: rtl/braille_pkg.sv
// Shared types, glyph constants and the braille-to-7-segment lookup for the
// braille entry terminal.
package braille_pkg;

  typedef logic [7:0] seg_t;

  typedef struct packed {
    logic valid;
    seg_t glyph;
  } decode_t;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_ARMING,
    DB_PRESSED,
    DB_RELEASE
  } db_state_t;

  localparam seg_t       GLYPH_BLANK = 8'hFF;
  localparam seg_t       GLYPH_DASH  = 8'hBF;
  localparam logic [5:0] PAT_SPACE   = 6'b000000;
  localparam logic [5:0] PAT_BKSP    = 6'b111111;

  // Segments listed active-high (bit0=a..bit6=g); the display wants active-low, dp off.
  function automatic seg_t lit(input logic [6:0] seg_on);
    return {1'b1, ~seg_on};
  endfunction

  // Pattern bits are {dot6, dot3, dot5, dot2, dot4, dot1}.
  // k, m, v, w and x have no true 7-segment form; the codes below are the house shapes.
  function automatic decode_t braille_to_glyph(input logic [5:0] p);
    decode_t    d;
    logic [6:0] seg_on;
    logic       valid;
    seg_on = '0;
    valid  = 1'b1;
    case (p)
      6'b000001: seg_on = 7'h77; // a
      6'b000101: seg_on = 7'h7C; // b
      6'b000011: seg_on = 7'h39; // c
      6'b001011: seg_on = 7'h5E; // d
      6'b001001: seg_on = 7'h79; // e
      6'b000111: seg_on = 7'h71; // f
      6'b001111: seg_on = 7'h3D; // g
      6'b001101: seg_on = 7'h76; // h
      6'b000110: seg_on = 7'h30; // i
      6'b001110: seg_on = 7'h1E; // j
      6'b010001: seg_on = 7'h75; // k
      6'b010101: seg_on = 7'h38; // l
      6'b010011: seg_on = 7'h37; // m
      6'b011011: seg_on = 7'h54; // n
      6'b011001: seg_on = 7'h5C; // o
      6'b010111: seg_on = 7'h73; // p
      6'b011111: seg_on = 7'h67; // q
      6'b011101: seg_on = 7'h50; // r
      6'b010110: seg_on = 7'h6D; // s
      6'b011110: seg_on = 7'h78; // t
      6'b110001: seg_on = 7'h3E; // u
      6'b110101: seg_on = 7'h1C; // v
      6'b101110: seg_on = 7'h2A; // w
      6'b110011: seg_on = 7'h49; // x
      6'b111011: seg_on = 7'h6E; // y
      6'b111001: seg_on = 7'h5B; // z
      default:   valid  = 1'b0;
    endcase
    d.valid = valid;
    d.glyph = valid ? lit(seg_on) : GLYPH_DASH;
    return d;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, four-state FSM and stability counter,
// emitting one press_strobe per physical press of an active-low key.
module key_debouncer
  import braille_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_strobe
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             key_prev_reg;
  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             strobe_reg, strobe_next;
  logic             key_sync;

  assign key_sync     = sync_reg[1];
  assign press_strobe = strobe_reg;

  // Synchroniser resets to "pressed" so a key held through reset needs a fresh
  // high-to-low edge before it can arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg     <= 2'b00;
      key_prev_reg <= 1'b0;
      state_reg    <= DB_IDLE;
      cnt_reg      <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], key_n};
      key_prev_reg <= key_sync;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      strobe_reg   <= strobe_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    strobe_next = 1'b0;
    case (state_reg)
      DB_IDLE: begin
        if (key_prev_reg && !key_sync) begin
          state_next = DB_ARMING;
          cnt_next   = '0;
        end
      end
      DB_ARMING: begin
        if (key_sync) begin
          state_next = DB_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = DB_PRESSED;
          strobe_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (key_sync) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (!key_sync) begin
          state_next = DB_PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DB_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/braille_hex_scroller.sv
// Braille entry terminal: debounced commit of a 6-dot cell from SW, decoded into a
// scrolling multi-digit 7-segment text buffer with space, backspace and error flag.
module braille_hex_scroller
  import braille_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic [1:0]              KEY,
  input  logic [5:0]              SW,
  output logic [NUM_DIGITS*8-1:0] HEX_OUT,
  output logic [3:0]              char_count,
  output logic                    commit,
  output logic                    err
);

  localparam logic [3:0] COUNT_MAX = 4'(NUM_DIGITS);

  logic [1:0] rst_sync_reg;
  logic       rst_n;
  logic [5:0] sw_meta_reg, sw_sync_reg;
  logic       press_strobe;

  seg_t       digit_reg  [NUM_DIGITS];
  seg_t       digit_next [NUM_DIGITS];
  logic [3:0] count_reg, count_next;
  logic       commit_reg, err_reg;

  decode_t    dec;
  seg_t       glyph_in;
  logic       do_shift, do_bksp, err_next;

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) rst_sync_reg <= 2'b00;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n = rst_sync_reg[1];

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= SW;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_commit_key (
    .clk         (CLOCK_50),
    .rst_n       (rst_n),
    .key_n       (KEY[1]),
    .press_strobe(press_strobe)
  );

  always_comb begin
    dec        = braille_to_glyph(sw_sync_reg);
    glyph_in   = (sw_sync_reg == PAT_SPACE) ? GLYPH_BLANK : dec.glyph;
    do_shift   = press_strobe && (sw_sync_reg != PAT_BKSP);
    do_bksp    = press_strobe && (sw_sync_reg == PAT_BKSP) && (count_reg != 4'd0);
    err_next   = press_strobe && (sw_sync_reg != PAT_SPACE) &&
                 (sw_sync_reg != PAT_BKSP) && !dec.valid;
    count_next = count_reg;
    if (do_shift && (count_reg != COUNT_MAX)) count_next = count_reg + 4'd1;
    else if (do_bksp)                         count_next = count_reg - 4'd1;
  end

  // Shift-in moves text toward the top digit; backspace pulls it back toward digit 0.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    seg_t up_src, down_src;
    if (gi == 0) begin : g_first
      assign up_src = glyph_in;
    end else begin : g_up
      assign up_src = digit_reg[gi-1];
    end
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign down_src = GLYPH_BLANK;
    end else begin : g_down
      assign down_src = digit_reg[gi+1];
    end
    assign digit_next[gi]       = do_shift ? up_src : (do_bksp ? down_src : digit_reg[gi]);
    assign HEX_OUT[gi*8 +: 8]   = digit_reg[gi];
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= GLYPH_BLANK;
      count_reg  <= 4'd0;
      commit_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= digit_next[i];
      count_reg  <= count_next;
      commit_reg <= press_strobe;
      err_reg    <= err_next;
    end
  end

  assign char_count = count_reg;
  assign commit     = commit_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_braille_hex_scroller.sv
// Self-checking bench for braille_hex_scroller: vector table plus hand-written
// bounce, backspace and reset-abort sequences, checked through a commit scoreboard.
module tb_braille_hex_scroller;

  logic        CLOCK_50 = 1'b0;
  logic [1:0]  KEY;
  logic [5:0]  SW;
  logic [31:0] HEX_OUT;
  logic [3:0]  char_count;
  logic        commit;
  logic        err;

  braille_hex_scroller #(
    .NUM_DIGITS     (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY       (KEY),
    .SW        (SW),
    .HEX_OUT   (HEX_OUT),
    .char_count(char_count),
    .commit    (commit),
    .err       (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] hex;
    logic [3:0]  cnt;
    logic        err;
  } exp_t;

  typedef struct {
    logic [5:0] sw;
    logic [7:0] glyph;
    logic       err;
    string      name;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vecs[16];
  int          n_vec = 0;
  int          n_err = 0;
  int          commit_cnt = 0;
  logic [31:0] exp_hex = 32'hFFFF_FFFF;
  int          exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  // Scoreboard: every commit pulse must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (commit) begin
      commit_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_commit", 32'(commit), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("commit_hex", HEX_OUT, mon_e.hex);
        check("commit_count", 32'(char_count), 32'(mon_e.cnt));
        check("commit_err", 32'(err), 32'(mon_e.err));
      end
      $display("commit #%0d: hex=%h count=%0d err=%0b", commit_cnt, HEX_OUT, char_count, err);
    end else if (err) begin
      check("err_without_commit", 32'(err), 32'd0);
    end
  end

  task automatic model_apply(input bit bksp, input logic [7:0] glyph, input logic e);
    if (bksp) begin
      if (exp_cnt > 0) begin
        exp_hex = {8'hFF, exp_hex[31:8]};
        exp_cnt--;
      end
    end else begin
      exp_hex = {exp_hex[23:0], glyph};
      if (exp_cnt < 4) exp_cnt++;
    end
    sb_q.push_back('{hex: exp_hex, cnt: 4'(exp_cnt), err: e});
  endtask

  task automatic press_expect(input logic [5:0] sw, input bit bksp, input logic [7:0] glyph,
                              input logic e, input string name);
    int start;
    model_apply(bksp, glyph, e);
    SW = sw;
    step(3);
    KEY[1] = 1'b0;
    start = commit_cnt;
    for (int i = 0; i < 40 && commit_cnt == start; i++) step(1);
    step(3);
    check({name, "_commit_pulses"}, 32'(commit_cnt - start), 32'd1);
    KEY[1] = 1'b1;
    step(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    vecs[0]  = '{6'h01, 8'h88, 1'b0, "a"};
    vecs[1]  = '{6'h03, 8'hC6, 1'b0, "c"};
    vecs[2]  = '{6'h05, 8'h83, 1'b0, "b"};
    vecs[3]  = '{6'h39, 8'hA4, 1'b0, "z"};
    vecs[4]  = '{6'h00, 8'hFF, 1'b0, "space"};
    vecs[5]  = '{6'h2E, 8'hD5, 1'b0, "w"};
    vecs[6]  = '{6'h11, 8'h8A, 1'b0, "k"};
    vecs[7]  = '{6'h2A, 8'hBF, 1'b1, "bad_456"};
    vecs[8]  = '{6'h3B, 8'h91, 1'b0, "y"};
    vecs[9]  = '{6'h1F, 8'h98, 1'b0, "q"};
    vecs[10] = '{6'h33, 8'hB6, 1'b0, "x"};
    vecs[11] = '{6'h13, 8'hC8, 1'b0, "m"};
    vecs[12] = '{6'h35, 8'hE3, 1'b0, "v"};
    vecs[13] = '{6'h1D, 8'hAF, 1'b0, "r"};
    vecs[14] = '{6'h02, 8'hBF, 1'b1, "bad_4"};
    vecs[15] = '{6'h0D, 8'h89, 1'b0, "h"};

    KEY = 2'b11;
    SW  = 6'h00;
    #5 KEY[0] = 1'b0;
    step(3);
    check("reset_hex", HEX_OUT, 32'hFFFF_FFFF);
    check("reset_count", 32'(char_count), 32'd0);
    check("reset_commit", 32'(commit), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    KEY[0] = 1'b1;
    step(6);

    for (int i = 0; i < 16; i++) begin
      press_expect(vecs[i].sw, 1'b0, vecs[i].glyph, vecs[i].err, vecs[i].name);
      if (i == 0) begin
        check("first_a_hex", HEX_OUT, 32'hFFFF_FF88);
        check("first_a_count", 32'(char_count), 32'd1);
      end
      if (i == 1) begin
        check("a_then_c_hex", HEX_OUT, 32'hFFFF_88C6);
        check("a_then_c_count", 32'(char_count), 32'd2);
      end
      if (vecs[i].err) check({vecs[i].name, "_dash"}, 32'(HEX_OUT[7:0]), 32'h0000_00BF);
    end

    // Bouncy press: three short glitches then a real hold; exactly one commit.
    model_apply(1'b0, 8'h89, 1'b0);
    SW = 6'h0D;
    step(3);
    start = commit_cnt;
    for (int b = 0; b < 3; b++) begin
      KEY[1] = 1'b0;
      step(2);
      KEY[1] = 1'b1;
      step(3);
    end
    KEY[1] = 1'b0;
    step(10);
    check("bounce_one_commit", 32'(commit_cnt - start), 32'd1);
    step(1000);
    check("hold_no_repeat", 32'(commit_cnt - start), 32'd1);
    KEY[1] = 1'b1;
    step(12);

    for (int i = 0; i < 5; i++)
      press_expect(vecs[i].sw, 1'b0, vecs[i].glyph, vecs[i].err, {"five_", vecs[i].name});
    check("five_count_saturated", 32'(char_count), 32'd4);
    for (int i = 0; i < 5; i++)
      press_expect(6'h3F, 1'b1, 8'h00, 1'b0, "bksp");
    check("bksp_all_blank", HEX_OUT, 32'hFFFF_FFFF);
    check("bksp_count_zero", 32'(char_count), 32'd0);

    // Reset while the key is still held in the pressed state.
    press_expect(vecs[5].sw, 1'b0, vecs[5].glyph, 1'b0, "pre_w");
    press_expect(vecs[6].sw, 1'b0, vecs[6].glyph, 1'b0, "pre_k");
    model_apply(1'b0, 8'h88, 1'b0);
    SW = 6'h01;
    step(3);
    KEY[1] = 1'b0;
    start = commit_cnt;
    for (int i = 0; i < 40 && commit_cnt == start; i++) step(1);
    step(3);
    check("third_char_commit", 32'(commit_cnt - start), 32'd1);
    check("third_char_count", 32'(char_count), 32'd3);
    KEY[0] = 1'b0;
    #1;
    check("async_reset_hex", HEX_OUT, 32'hFFFF_FFFF);
    check("async_reset_count", 32'(char_count), 32'd0);
    check("async_reset_commit", 32'(commit), 32'd0);
    exp_hex = 32'hFFFF_FFFF;
    exp_cnt = 0;
    step(3);
    KEY[0] = 1'b1;
    start = commit_cnt;
    step(20);
    KEY[1] = 1'b1;
    step(20);
    check("no_commit_after_reset", 32'(commit_cnt - start), 32'd0);
    check("post_reset_hex", HEX_OUT, 32'hFFFF_FFFF);
    check("post_reset_count", 32'(char_count), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
